// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
package mult_pkg;
  localparam int WIDTH      = 8;
  localparam int PROD_WIDTH = 16;
  localparam int STEPS      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-style adder with carry in/out; used for the multiplier's partial-product step.
module adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  assign {Cout, Sum} = 9'(A) + 9'(B) + 9'(Cin);
endmodule

// File: rtl/mult_8bit_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial-product step per cycle,
// with a Start/Busy/Done handshake and a held Product register.
module mult_8bit_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  output logic                  Busy,
  output logic                  Done,
  output logic [PROD_WIDTH-1:0] Product
);

  if (WIDTH != 8) begin : g_bad_width
    $error("mult_8bit_seq: only WIDTH=8 is supported");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mcand;
  logic [7:0]            r_hi;
  logic [7:0]            r_lo;
  logic                  r_c;
  logic [2:0]            r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [PROD_WIDTH-1:0] r_product;
  logic [7:0]            w_sum;
  logic                  w_cout;
  logic [16:0]           w_acc;
  logic                  w_last_step;

  adder_8bit u_adder (
    .A    (r_hi),
    .B    (r_mcand),
    .Cin  (1'b0),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  assign w_last_step = (r_cnt == 3'(STEPS - 1));

  // Pre-shift accumulator; C is always zero at the start of a step, so the
  // no-add path carries it through unchanged.
  always_comb begin
    w_acc = {r_c, r_hi, r_lo};
    if (r_lo[0]) begin
      w_acc = {w_cout, w_sum, r_lo};
    end else begin
      w_acc = {r_c, r_hi, r_lo};
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_last_step) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, shift-add datapath and product latch.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_mcand   <= 8'h00;
      r_hi      <= 8'h00;
      r_lo      <= 8'h00;
      r_c       <= 1'b0;
      r_cnt     <= 3'd0;
      r_product <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_mcand <= A;
            r_lo    <= B;
            r_hi    <= 8'h00;
            r_c     <= 1'b0;
            r_cnt   <= 3'd0;
          end
        end
        ST_CALC: begin
          {r_c, r_hi, r_lo} <= w_acc >> 1;
          r_cnt             <= r_cnt + 3'd1;
        end
        ST_DONE: r_product <= {r_hi, r_lo};
        default: ;
      endcase
    end
  end

  // Handshake outputs registered from the current state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_CALC) || (r_state == ST_DONE);
      r_done <= (r_state == ST_DONE);
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Product = r_product;

endmodule
